// File: rtl/trellis_phase_error_pkg.sv
// trellis_pkg: shared widths, FSM state type and arithmetic helpers for the
// trellis carrier-loop phase-error generator.
//   SAMPLE_W    - received/reference sample width (signed Q1.17)
//   PHERR_W     - phase-error output width (signed Q1.9)
//   ROUND_SHIFT - right shift taking the Q4.34 sum down to Q4.9
package trellis_pkg;

  localparam int SAMPLE_W    = 18;
  localparam int PHERR_W     = 10;
  localparam int ROUND_SHIFT = 25;
  localparam int PROD_W      = 2 * SAMPLE_W;        // Q2.34 product
  localparam int SUM_W       = PROD_W + 2;          // four-term sum headroom
  localparam int PAIR_W      = 4 * SAMPLE_W;        // {i0,q0,i1,q1}
  localparam int SHR_W       = SUM_W - ROUND_SHIFT; // width left after shift

  localparam logic signed [SUM_W-1:0] ROUND_BIAS = 38'sd16777216; // 2^24
  localparam logic signed [SHR_W-1:0] SAT_MAX    = 13'sd511;
  localparam logic signed [SHR_W-1:0] SAT_MIN    = -13'sd512;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Full-precision signed multiply; operands are sign-extended first so the
  // product never depends on context width rules.
  function automatic logic signed [PROD_W-1:0] mul_s(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b
  );
    logic signed [PROD_W-1:0] a_x;
    logic signed [PROD_W-1:0] b_x;
    a_x = PROD_W'(a);
    b_x = PROD_W'(b);
    return a_x * b_x;
  endfunction

  // Round-half-up, arithmetic shift, then clamp to the Q1.9 output range.
  function automatic logic signed [PHERR_W-1:0] round_sat(
    input logic signed [SUM_W-1:0] sum
  );
    logic signed [SUM_W-1:0] biased;
    logic signed [SHR_W-1:0] shr;
    logic signed [PHERR_W-1:0] res;
    biased = sum + ROUND_BIAS;
    shr    = biased[SUM_W-1:ROUND_SHIFT];
    if (shr > SAT_MAX) begin
      res = 10'sh1FF;
    end else if (shr < SAT_MIN) begin
      res = 10'sh200;
    end else begin
      res = shr[PHERR_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/trellis_phase_error_if.sv
// trellis_phase_error_if: sample, decision and phase-error signals of the
// phase-error generator.
//   master - drives samples/enables/references/faultClear, observes outputs
//   slave  - the generator itself
interface trellis_phase_error_if;
  import trellis_pkg::*;

  logic                       sym2xEn;
  logic                       symEn;
  logic signed [SAMPLE_W-1:0] iIn;
  logic signed [SAMPLE_W-1:0] qIn;
  logic                       decisionValid;
  logic signed [SAMPLE_W-1:0] iRef0;
  logic signed [SAMPLE_W-1:0] qRef0;
  logic signed [SAMPLE_W-1:0] iRef1;
  logic signed [SAMPLE_W-1:0] qRef1;
  logic                       faultClear;
  logic signed [PHERR_W-1:0]  phaseErrorReal;
  logic signed [PHERR_W-1:0]  phaseErrorImag;
  logic                       symEn_phErr;
  logic [5:0]                 fifoLevel;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output sym2xEn, symEn, iIn, qIn, decisionValid,
           iRef0, qRef0, iRef1, qRef1, faultClear,
    input  phaseErrorReal, phaseErrorImag, symEn_phErr,
           fifoLevel, overflow, underflow
  );

  modport slave (
    input  sym2xEn, symEn, iIn, qIn, decisionValid,
           iRef0, qRef0, iRef1, qRef1, faultClear,
    output phaseErrorReal, phaseErrorImag, symEn_phErr,
           fifoLevel, overflow, underflow
  );

endinterface

// File: rtl/trellis_sym_fifo.sv
// trellis_sym_fifo: synchronous FIFO of symbol pairs with flush.
//   clk_i/rst_ni  - clock, asynchronous active-low reset
//   push_i/pop_i  - write/read strobes (ignored when full/empty, except a
//                   push at full is accepted alongside a pop)
//   flush_i       - empties the FIFO, overrides push/pop
//   wdata_i       - pair to write; rdata_o - oldest pair (combinational)
//   level_o       - occupancy; full_o/empty_o - status
module trellis_sym_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 72,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (level_q == LW'(DEPTH));
  assign empty_s   = (level_q == '0);
  // At full the read of the old slot and the write of the same slot share an
  // edge; the read is combinational so the old pair is consumed intact.
  assign push_ok_s = push_i && (!full_s || pop_i);
  assign pop_ok_s  = pop_i && !empty_s;

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_s;
  assign empty_o = empty_s;

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/trellis_phase_error.sv
// trellis_phase_error: buffers 2x-rate sample pairs until the trellis detector
// releases the reference waveform, then correlates z = s0*conj(r0) +
// s1*conj(r1) and emits a rounded, saturated Q1.9 phase error with a strobe
// three cycles after the decision.
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - sample/decision inputs and phase-error/status outputs
module trellis_phase_error
  import trellis_pkg::*;
#(
  parameter int FIFO_DEPTH = 32
) (
  input logic            clk,
  input logic            reset,
  trellis_phase_error_if.slave bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_e                     state_q, state_d;
  logic                       half_valid_q;
  logic [2*SAMPLE_W-1:0]      half_q;
  logic [2*SAMPLE_W-1:0]      sample_s;
  logic                       push_req_s;
  logic                       push_s, pop_s, flush_s;
  logic                       set_ovf_s, set_udf_s, clr_flags_s;
  logic                       overflow_q, underflow_q;
  logic [PAIR_W-1:0]          rdata_s;
  logic [LVL_W-1:0]           level_s;
  logic                       full_s, empty_s, one_s;
  logic signed [SAMPLE_W-1:0] s_i0_s, s_q0_s, s_i1_s, s_q1_s;
  logic signed [PROD_W-1:0]   prod_d [8];
  logic signed [PROD_W-1:0]   prod_q [8];
  logic                       v1_q, v2_q;
  logic signed [SUM_W-1:0]    sum_re_d, sum_im_d, sum_re_q, sum_im_q;
  logic signed [PHERR_W-1:0]  pe_re_q, pe_im_q;
  logic                       strobe_q;

  assign sample_s   = {bus.iIn, bus.qIn};
  assign push_req_s = bus.sym2xEn && bus.symEn && half_valid_q && (state_q != FAULT);
  assign one_s      = (level_s == LVL_W'(1));

  trellis_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .wdata_i ({half_q, sample_s}),
    .rdata_o (rdata_s),
    .level_o (level_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // First-half latch: a symEn sample completes a pair only if a first half is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_valid_q <= 1'b0;
      half_q       <= '0;
    end else if (state_q == FAULT) begin
      half_valid_q <= 1'b0;
    end else if (bus.sym2xEn && !bus.symEn) begin
      half_valid_q <= 1'b1;
      half_q       <= sample_s;
    end else if (bus.sym2xEn && bus.symEn) begin
      half_valid_q <= 1'b0;
    end else begin
      half_valid_q <= half_valid_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and FIFO/flag controls.
  always_comb begin
    state_d     = state_q;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    set_ovf_s   = 1'b0;
    set_udf_s   = 1'b0;
    clr_flags_s = 1'b0;
    case (state_q)
      EMPTY: begin
        // A decision with nothing buffered is an underflow even if a pair
        // arrives in the same cycle.
        if (bus.decisionValid) begin
          set_udf_s = 1'b1;
          state_d   = FAULT;
        end else if (push_req_s) begin
          push_s  = 1'b1;
          state_d = TRACK;
        end else begin
          state_d = EMPTY;
        end
      end
      TRACK: begin
        if (bus.decisionValid && empty_s) begin
          set_udf_s = 1'b1;
          state_d   = FAULT;
        end else if (push_req_s && full_s && !bus.decisionValid) begin
          set_ovf_s = 1'b1;
          state_d   = FAULT;
        end else begin
          push_s = push_req_s;
          pop_s  = bus.decisionValid;
          if (bus.decisionValid && one_s && !push_req_s) begin
            state_d = EMPTY;
          end else begin
            state_d = TRACK;
          end
        end
      end
      FAULT: begin
        if (bus.faultClear) begin
          clr_flags_s = 1'b1;
          state_d     = EMPTY;
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        state_d = FAULT;
      end
    endcase
    // Flushing on the entry edge as well means the level reads 0 as soon as
    // FAULT is visible.
    flush_s = (state_d == FAULT);
  end

  // Sticky fault flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr_flags_s) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | set_ovf_s;
      underflow_q <= underflow_q | set_udf_s;
    end
  end

  // Stage 1 operands: oldest pair against the references presented with the decision.
  always_comb begin
    s_i0_s    = rdata_s[4*SAMPLE_W-1:3*SAMPLE_W];
    s_q0_s    = rdata_s[3*SAMPLE_W-1:2*SAMPLE_W];
    s_i1_s    = rdata_s[2*SAMPLE_W-1:SAMPLE_W];
    s_q1_s    = rdata_s[SAMPLE_W-1:0];
    prod_d[0] = mul_s(s_i0_s, bus.iRef0);
    prod_d[1] = mul_s(s_q0_s, bus.qRef0);
    prod_d[2] = mul_s(s_q0_s, bus.iRef0);
    prod_d[3] = mul_s(s_i0_s, bus.qRef0);
    prod_d[4] = mul_s(s_i1_s, bus.iRef1);
    prod_d[5] = mul_s(s_q1_s, bus.qRef1);
    prod_d[6] = mul_s(s_q1_s, bus.iRef1);
    prod_d[7] = mul_s(s_i1_s, bus.qRef1);
  end

  // Stage 1 register: products.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      prod_q <= '{default: '0};
    end else begin
      v1_q <= pop_s;
      if (pop_s) begin
        prod_q <= prod_d;
      end
    end
  end

  // Stage 2 operands: real and imaginary four-term sums.
  always_comb begin
    sum_re_d = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1])
             + SUM_W'(prod_q[4]) + SUM_W'(prod_q[5]);
    sum_im_d = SUM_W'(prod_q[2]) - SUM_W'(prod_q[3])
             + SUM_W'(prod_q[6]) - SUM_W'(prod_q[7]);
  end

  // Stage 2 register: sums.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_q     <= 1'b0;
      sum_re_q <= '0;
      sum_im_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_re_q <= sum_re_d;
        sum_im_q <= sum_im_d;
      end
    end
  end

  // Stage 3 register: rounded/saturated outputs, held between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_q <= 1'b0;
      pe_re_q  <= '0;
      pe_im_q  <= '0;
    end else begin
      strobe_q <= v2_q;
      if (v2_q) begin
        pe_re_q <= round_sat(sum_re_q);
        pe_im_q <= round_sat(sum_im_q);
      end
    end
  end

  assign bus.phaseErrorReal = pe_re_q;
  assign bus.phaseErrorImag = pe_im_q;
  assign bus.symEn_phErr    = strobe_q;
  assign bus.fifoLevel      = 6'(level_s);
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;

endmodule

// File: tb/tb_trellis_phase_error.sv
// Testbench for trellis_phase_error: a pair model and a scoreboard of
// expected phase errors (value and due cycle) checked when the strobe fires.
module tb_trellis_phase_error;
  import trellis_pkg::*;

  typedef struct {int i0; int q0; int i1; int q1;} pair_t;
  typedef struct {int re; int im; int due;} exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  pair_t mdl_q[$];
  exp_t  exp_q[$];
  exp_t  mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  trellis_phase_error_if bus();

  trellis_phase_error #(.FIFO_DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int scale(input longint v);
    longint t;
    t = (v + 64'sd16777216) >>> 25;
    if (t > 511) return 511;
    if (t < -512) return -512;
    return int'(t);
  endfunction

  function automatic exp_t model_corr(input pair_t s, input pair_t r, input int due);
    exp_t e;
    longint re, im;
    re = longint'(s.i0) * r.i0 + longint'(s.q0) * r.q0
       + longint'(s.i1) * r.i1 + longint'(s.q1) * r.q1;
    im = longint'(s.q0) * r.i0 - longint'(s.i0) * r.q0
       + longint'(s.q1) * r.i1 - longint'(s.i1) * r.q1;
    e.re  = scale(re);
    e.im  = scale(im);
    e.due = due;
    return e;
  endfunction

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  function automatic pair_t rnd_pair();
    pair_t p;
    p.i0 = rnd18(); p.q0 = rnd18(); p.i1 = rnd18(); p.q1 = rnd18();
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive (or withdraw) a decision; when it is expected to pop, model the pop.
  task automatic set_dec(input bit dv, input bit ok, input pair_t r);
    pair_t s;
    pair_t junk;
    if (dv) begin
      bus.decisionValid = 1'b1;
      bus.iRef0 = 18'(r.i0); bus.qRef0 = 18'(r.q0);
      bus.iRef1 = 18'(r.i1); bus.qRef1 = 18'(r.q1);
      if (ok && mdl_q.size() > 0) begin
        s = mdl_q.pop_front();
        exp_q.push_back(model_corr(s, r, cyc_cnt + 3));
      end
    end else begin
      junk = rnd_pair();
      bus.decisionValid = 1'b0;
      bus.iRef0 = 18'(junk.i0); bus.qRef0 = 18'(junk.q0);
      bus.iRef1 = 18'(junk.i1); bus.qRef1 = 18'(junk.q1);
    end
  endtask

  task automatic push_pair(input pair_t p, input bit accept, input bit dv, input pair_t r);
    bus.sym2xEn = 1'b1; bus.symEn = 1'b0;
    bus.iIn = 18'(p.i0); bus.qIn = 18'(p.q0);
    set_dec(1'b0, 1'b0, r);
    tick();
    bus.symEn = 1'b1;
    bus.iIn = 18'(p.i1); bus.qIn = 18'(p.q1);
    set_dec(dv, 1'b1, r);
    if (accept) mdl_q.push_back(p);
    tick();
    bus.sym2xEn = 1'b0; bus.symEn = 1'b0;
    set_dec(1'b0, 1'b0, r);
  endtask

  task automatic decide(input pair_t r, input bit ok);
    set_dec(1'b1, ok, r);
    tick();
    set_dec(1'b0, 1'b0, r);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fault_clear();
    bus.faultClear = 1'b1;
    tick();
    bus.faultClear = 1'b0;
  endtask

  // Scoreboard: every strobe must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && cyc_cnt > exp_q[0].due) begin
      check_eq("strobe_missing", cyc_cnt, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (bus.symEn_phErr === 1'b1) begin
      check_eq("strobe_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_eq("pherr_real", bus.phaseErrorReal, mon_e.re);
        check_eq("pherr_imag", bus.phaseErrorImag, mon_e.im);
        check_eq("strobe_cycle", cyc_cnt, mon_e.due);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    pair_t half_p, quad_s, full_p, neg_s, neg_r, zero_p;
    half_p = '{65536, 0, 65536, 0};
    quad_s = '{0, 65536, 0, 65536};
    full_p = '{131071, 131071, 131071, 131071};
    neg_s  = '{-131072, 0, -131072, 0};
    neg_r  = '{131071, 0, 131071, 0};
    zero_p = '{0, 0, 0, 0};

    reset = 1'b0;
    bus.sym2xEn = 1'b0; bus.symEn = 1'b0; bus.iIn = '0; bus.qIn = '0;
    bus.faultClear = 1'b0;
    set_dec(1'b0, 1'b0, zero_p);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_real", bus.phaseErrorReal, 0);
    check_eq("rst_imag", bus.phaseErrorImag, 0);
    check_eq("rst_strobe", bus.symEn_phErr, 0);
    check_eq("rst_level", bus.fifoLevel, 0);
    check_eq("rst_overflow", bus.overflow, 0);
    check_eq("rst_underflow", bus.underflow, 0);
    reset = 1'b1;
    idle(2);

    // Decision with nothing buffered.
    decide(zero_p, 1'b0);
    @(negedge clk);
    check_eq("udf_flag", bus.underflow, 1);
    check_eq("udf_level", bus.fifoLevel, 0);
    idle(5);
    fault_clear();
    @(negedge clk);
    check_eq("udf_cleared", bus.underflow, 0);

    // Orphan second sample is dropped; then zero rotation, with a pop still
    // in flight when an underflow forces FAULT.
    bus.sym2xEn = 1'b1; bus.symEn = 1'b1; bus.iIn = 18'sd1000; bus.qIn = 18'sd2000;
    tick();
    bus.sym2xEn = 1'b0; bus.symEn = 1'b0;
    idle(1);
    @(negedge clk);
    check_eq("drop_level", bus.fifoLevel, 0);
    push_pair(half_p, 1'b1, 1'b0, zero_p);
    @(negedge clk);
    check_eq("one_level", bus.fifoLevel, 1);
    decide(half_p, 1'b1);
    decide(half_p, 1'b0);
    idle(5);
    @(negedge clk);
    check_eq("inflight_udf", bus.underflow, 1);
    check_eq("hold_real", bus.phaseErrorReal, 256);
    fault_clear();

    // Level 3, simultaneous push+pop, then back-to-back pops.
    push_pair(quad_s, 1'b1, 1'b0, zero_p);
    push_pair(full_p, 1'b1, 1'b0, zero_p);
    push_pair(neg_s, 1'b1, 1'b0, zero_p);
    @(negedge clk);
    check_eq("lvl3", bus.fifoLevel, 3);
    push_pair(rnd_pair(), 1'b1, 1'b1, half_p);
    @(negedge clk);
    check_eq("lvl3_pushpop", bus.fifoLevel, 3);
    decide(full_p, 1'b1);
    decide(neg_r, 1'b1);
    decide(rnd_pair(), 1'b1);
    idle(6);
    @(negedge clk);
    check_eq("drained_level", bus.fifoLevel, 0);

    // Fill to depth, then overflow.
    for (int n = 0; n < 32; n++) push_pair(rnd_pair(), 1'b1, 1'b0, zero_p);
    @(negedge clk);
    check_eq("full_level", bus.fifoLevel, 32);
    push_pair(rnd_pair(), 1'b0, 1'b0, zero_p);
    @(negedge clk);
    check_eq("ovf_flag", bus.overflow, 1);
    check_eq("ovf_level", bus.fifoLevel, 0);
    mdl_q.delete();
    idle(3);
    fault_clear();
    @(negedge clk);
    check_eq("ovf_cleared", bus.overflow, 0);
    for (int n = 0; n < 3; n++) push_pair(rnd_pair(), 1'b1, 1'b0, zero_p);
    for (int n = 0; n < 3; n++) decide(rnd_pair(), 1'b1);
    idle(6);

    // Random traffic with pops coinciding with pushes.
    for (int n = 0; n < 30; n++) begin
      bit dv;
      dv = (mdl_q.size() > 0) && ($urandom_range(0, 1) == 1);
      push_pair(rnd_pair(), 1'b1, dv, rnd_pair());
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    while (mdl_q.size() > 0) decide(rnd_pair(), 1'b1);
    idle(6);

    // Reset in the middle of the pipeline kills the strobe.
    push_pair(full_p, 1'b1, 1'b0, zero_p);
    decide(full_p, 1'b1);
    tick();
    reset = 1'b0;
    exp_q.delete();
    mdl_q.delete();
    idle(2);
    reset = 1'b1;
    idle(6);
    @(negedge clk);
    check_eq("mrst_level", bus.fifoLevel, 0);
    check_eq("mrst_real", bus.phaseErrorReal, 0);
    check_eq("mrst_strobe", bus.symEn_phErr, 0);

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
